// File: rtl/mlaccel_memarb_pkg.sv
// Shared definitions for the main-memory arbiter: client tags, default geometry
// and the saturating smem wait-counter helper.
package mlaccel_memarb_pkg;

   typedef enum logic [1:0] {
      CL_NONE = 2'd0,
      CL_CMP  = 2'd1,
      CL_QPI  = 2'd2,
      CL_SEQ  = 2'd3
   } client_e;

   localparam int unsigned DEF_ADDR_W     = 16;
   localparam int unsigned DEF_DATA_W     = 64;
   localparam int unsigned DEF_RD_LAT     = 1;
   localparam int unsigned DEF_STARVE_MAX = 15;
   localparam int unsigned WAIT_W         = 8;

   typedef logic [WAIT_W-1:0] wait_cnt_t;

   function automatic wait_cnt_t wait_sat_inc(input wait_cnt_t cnt, input wait_cnt_t lim);
      wait_cnt_t res;
      if (cnt >= lim) begin
         res = lim;
      end else begin
         res = cnt + 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mlaccel_memarb_if.sv
// Bus bundle between the three memory clients, the arbiter and the memory port.
// slave = arbiter side, master = requesters plus memory model.
interface mlaccel_memarb_if
   import mlaccel_memarb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              c_ren;
   logic [BE_W-1:0]   c_wen;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_done;

   logic              q_req;
   logic [BE_W-1:0]   q_wen;
   logic [ADDR_W-1:0] q_addr;
   logic [DATA_W-1:0] q_wdata;
   logic              q_gnt;
   logic              q_done;

   logic              s_req;
   logic [ADDR_W-1:0] s_addr;
   logic              s_gnt;
   logic              s_done;
   logic              s_starved;

   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] m_addr;
   logic [BE_W-1:0]   m_wen;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  c_ren, c_wen, c_addr, c_wdata,
      output c_done,
      input  q_req, q_wen, q_addr, q_wdata,
      output q_gnt, q_done,
      input  s_req, s_addr,
      output s_gnt, s_done, s_starved,
      output rd_data, m_addr, m_wen, m_wdata,
      input  m_rdata
   );

   modport master (
      output c_ren, c_wen, c_addr, c_wdata,
      input  c_done,
      output q_req, q_wen, q_addr, q_wdata,
      input  q_gnt, q_done,
      output s_req, s_addr,
      input  s_gnt, s_done, s_starved,
      input  rd_data, m_addr, m_wen, m_wdata,
      output m_rdata
   );

endinterface

// File: rtl/mlaccel_memarb_tagpipe.sv
// Client-tag delay line: a tag enters with each issued access and falls out of the
// last stage in the cycle the memory presents that access's read data.
module mlaccel_memarb_tagpipe
   import mlaccel_memarb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    i_clock,
   input  logic    i_resetn,
   input  client_e i_tag,
   output client_e o_tag,
   output logic    o_busy_qpi,
   output logic    o_busy_seq
);

   client_e r_stage [DEPTH];
   logic    w_busy_qpi;
   logic    w_busy_seq;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_stage[i] <= CL_NONE;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   // The final stage is the done cycle, so it does not hold its client off.
   always_comb begin
      w_busy_qpi = 1'b0;
      w_busy_seq = 1'b0;
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         case (r_stage[i])
            CL_QPI:  w_busy_qpi = 1'b1;
            CL_SEQ:  w_busy_seq = 1'b1;
            default: begin end
         endcase
      end
   end

   assign o_tag      = r_stage[DEPTH-1];
   assign o_busy_qpi = w_busy_qpi;
   assign o_busy_seq = w_busy_seq;

endmodule

// File: rtl/mlaccel_memarb.sv
// Single-port main-memory arbiter: compute has absolute priority, qmem beats smem
// unless smem has waited STARVE_MAX cycles. Winner is registered onto the memory port.
module mlaccel_memarb
   import mlaccel_memarb_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RD_LAT     = DEF_RD_LAT,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic            i_clock,
   input  logic            i_resetn,
   mlaccel_memarb_if.slave io_bus
);

   localparam int unsigned BE_W       = DATA_W / 8;
   localparam int unsigned DEPTH      = RD_LAT + 1;
   localparam wait_cnt_t   STARVE_LIM = WAIT_W'(STARVE_MAX);

   logic              w_c_act;
   logic              w_q_elig;
   logic              w_s_elig;
   logic              w_q_busy;
   logic              w_s_busy;
   client_e           w_win;
   client_e           w_tag_done;

   wait_cnt_t         r_wait_cnt;
   wait_cnt_t         w_wait_nxt;
   logic              r_s_starved;

   logic [ADDR_W-1:0] r_m_addr;
   logic [BE_W-1:0]   r_m_wen;
   logic [DATA_W-1:0] r_m_wdata;
   logic [ADDR_W-1:0] w_nxt_addr;
   logic [BE_W-1:0]   w_nxt_wen;
   logic [DATA_W-1:0] w_nxt_wdata;

   assign w_c_act  = io_bus.c_ren | (|io_bus.c_wen);
   assign w_q_elig = io_bus.q_req & ~w_q_busy;
   assign w_s_elig = io_bus.s_req & ~w_s_busy;

   always_comb begin
      w_win = CL_NONE;
      if (w_c_act) begin
         w_win = CL_CMP;
      end else if (w_s_elig && r_s_starved) begin
         w_win = CL_SEQ;
      end else if (w_q_elig) begin
         w_win = CL_QPI;
      end else if (w_s_elig) begin
         w_win = CL_SEQ;
      end else begin
         w_win = CL_NONE;
      end
   end

   // Idle cycles hold the address and data and only clear the byte enables.
   always_comb begin
      w_nxt_addr  = r_m_addr;
      w_nxt_wen   = {BE_W{1'b0}};
      w_nxt_wdata = r_m_wdata;
      case (w_win)
         CL_CMP: begin
            w_nxt_addr  = io_bus.c_addr;
            w_nxt_wen   = io_bus.c_wen;
            w_nxt_wdata = io_bus.c_wdata;
         end
         CL_QPI: begin
            w_nxt_addr  = io_bus.q_addr;
            w_nxt_wen   = io_bus.q_wen;
            w_nxt_wdata = io_bus.q_wdata;
         end
         CL_SEQ: begin
            w_nxt_addr  = io_bus.s_addr;
         end
         default: begin end
      endcase
   end

   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (w_win == CL_SEQ) begin
         w_wait_nxt = 8'd0;
      end else if (w_s_elig) begin
         w_wait_nxt = wait_sat_inc(r_wait_cnt, STARVE_LIM);
      end else begin
         w_wait_nxt = r_wait_cnt;
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_m_addr    <= {ADDR_W{1'b0}};
         r_m_wen     <= {BE_W{1'b0}};
         r_m_wdata   <= {DATA_W{1'b0}};
         r_wait_cnt  <= 8'd0;
         r_s_starved <= 1'b0;
      end else begin
         r_m_addr    <= w_nxt_addr;
         r_m_wen     <= w_nxt_wen;
         r_m_wdata   <= w_nxt_wdata;
         r_wait_cnt  <= w_wait_nxt;
         r_s_starved <= (w_wait_nxt == STARVE_LIM);
      end
   end

   mlaccel_memarb_tagpipe #(
      .DEPTH (DEPTH)
   ) u_tagpipe (
      .i_clock    (i_clock),
      .i_resetn   (i_resetn),
      .i_tag      (w_win),
      .o_tag      (w_tag_done),
      .o_busy_qpi (w_q_busy),
      .o_busy_seq (w_s_busy)
   );

   assign io_bus.q_gnt     = i_resetn & (w_win == CL_QPI);
   assign io_bus.s_gnt     = i_resetn & (w_win == CL_SEQ);
   assign io_bus.c_done    = (w_tag_done == CL_CMP);
   assign io_bus.q_done    = (w_tag_done == CL_QPI);
   assign io_bus.s_done    = (w_tag_done == CL_SEQ);
   assign io_bus.s_starved = r_s_starved;
   assign io_bus.rd_data   = io_bus.m_rdata;
   assign io_bus.m_addr    = r_m_addr;
   assign io_bus.m_wen     = r_m_wen;
   assign io_bus.m_wdata   = r_m_wdata;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed and random bench for mlaccel_memarb against a queue-based model of the
// arbitration rules plus a reference memory image.
module tb_mlaccel_memarb;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 64;
   localparam int RD_LAT     = 1;
   localparam int STARVE_MAX = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mlaccel_memarb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mlaccel_memarb #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .i_clock (clk),
      .i_resetn(rst_n),
      .io_bus  (bus)
   );

   function automatic logic [63:0] pat(input int a);
      return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h0101_0101};
   endfunction

   // Synchronous-read memory; contents reload from the pattern while reset is low.
   logic [63:0] phys_mem [256];
   logic [63:0] phys_rd;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) phys_mem[i] <= pat(i);
      end else begin
         for (int b = 0; b < 8; b++)
            if (bus.m_wen[b]) phys_mem[bus.m_addr[7:0]][b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
      end
      phys_rd <= phys_mem[bus.m_addr[7:0]];
   end
   assign bus.m_rdata = phys_rd;

   typedef struct {
      int          cl;
      int          due;
      bit          rd;
      logic [63:0] exp;
   } fl_t;

   fl_t         fl_q[$];
   logic [63:0] ref_mem [256];
   int          cyc;
   int          wait_cnt;
   logic [15:0] exp_maddr;
   logic [7:0]  exp_mwen;
   logic [63:0] exp_mwdata;
   int          checks = 0;
   int          errors = 0;
   bit          obs_cd, obs_qd, obs_sd, obs_qg, obs_sg;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      fl_q.delete();
      wait_cnt   = 0;
      cyc        = 0;
      exp_maddr  = 16'h0000;
      exp_mwen   = 8'h00;
      exp_mwdata = 64'h0;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
   endtask

   task automatic idle_inputs();
      bus.c_ren = 1'b0; bus.c_wen = 8'h00; bus.c_addr = 16'h0000; bus.c_wdata = 64'h0;
      bus.q_req = 1'b0; bus.q_wen = 8'h00; bus.q_addr = 16'h0000; bus.q_wdata = 64'h0;
      bus.s_req = 1'b0; bus.s_addr = 16'h0000;
   endtask

   task automatic hold_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_c_done", bus.c_done, 64'd0);
         chk("rst_q_done", bus.q_done, 64'd0);
         chk("rst_s_done", bus.s_done, 64'd0);
         chk("rst_q_gnt", bus.q_gnt, 64'd0);
         chk("rst_s_gnt", bus.s_gnt, 64'd0);
         chk("rst_starved", bus.s_starved, 64'd0);
         chk("rst_m_wen", bus.m_wen, 64'd0);
         chk("rst_m_addr", bus.m_addr, 64'd0);
         chk("rst_m_wdata", bus.m_wdata, 64'd0);
         @(posedge clk); #1;
      end
      idle_inputs();
      reset_model();
      rst_n = 1'b1;
   endtask

   // One clock: compare outputs with the model, apply the priority rules, advance.
   task automatic step();
      bit          c_act, qb, sb, starved, rd_chk, gq, gs;
      bit          exp_done [4];
      logic [63:0] exp_rd, d;
      logic [15:0] a;
      logic [7:0]  w;
      int          win;
      fl_t         e;
      fl_t         keep[$];
      for (int i = 0; i < 4; i++) exp_done[i] = 1'b0;
      qb = 1'b0; sb = 1'b0; rd_chk = 1'b0; exp_rd = 64'h0;
      @(negedge clk);
      foreach (fl_q[i]) begin
         if (fl_q[i].due > cyc) begin
            if (fl_q[i].cl == 2) qb = 1'b1;
            if (fl_q[i].cl == 3) sb = 1'b1;
         end
         if (fl_q[i].due == cyc) begin
            exp_done[fl_q[i].cl] = 1'b1;
            if (fl_q[i].rd) begin rd_chk = 1'b1; exp_rd = fl_q[i].exp; end
         end
      end
      starved = (wait_cnt == STARVE_MAX);
      obs_cd = bus.c_done; obs_qd = bus.q_done; obs_sd = bus.s_done;
      obs_qg = bus.q_gnt;  obs_sg = bus.s_gnt;
      chk("c_done", bus.c_done, 64'(exp_done[1]));
      chk("q_done", bus.q_done, 64'(exp_done[2]));
      chk("s_done", bus.s_done, 64'(exp_done[3]));
      if (rd_chk) chk("rd_data", bus.rd_data, exp_rd);
      chk("s_starved", bus.s_starved, 64'(starved));
      chk("m_wen", bus.m_wen, 64'(exp_mwen));
      chk("m_addr", bus.m_addr, 64'(exp_maddr));
      if (exp_mwen != 8'h00) chk("m_wdata", bus.m_wdata, exp_mwdata);

      c_act = bus.c_ren || (bus.c_wen != 8'h00);
      win = 0;
      if (c_act) win = 1;
      else if (bus.s_req && !sb && starved) win = 3;
      else if (bus.q_req && !qb) win = 2;
      else if (bus.s_req && !sb) win = 3;
      gq = (win == 2); gs = (win == 3);
      chk("q_gnt", bus.q_gnt, 64'(gq));
      chk("s_gnt", bus.s_gnt, 64'(gs));

      if (gs) wait_cnt = 0;
      else if (bus.s_req && !sb && wait_cnt < STARVE_MAX) wait_cnt++;

      foreach (fl_q[i]) if (fl_q[i].due > cyc) keep.push_back(fl_q[i]);
      fl_q = keep;
      if (win != 0) begin
         case (win)
            1:       begin a = bus.c_addr; w = bus.c_wen; d = bus.c_wdata; end
            2:       begin a = bus.q_addr; w = bus.q_wen; d = bus.q_wdata; end
            default: begin a = bus.s_addr; w = 8'h00;     d = 64'h0;       end
         endcase
         e.cl = win; e.due = cyc + 1 + RD_LAT; e.rd = (w == 8'h00); e.exp = ref_mem[a[7:0]];
         for (int b = 0; b < 8; b++) if (w[b]) ref_mem[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
         fl_q.push_back(e);
         exp_maddr = a; exp_mwen = w;
         if (w != 8'h00) exp_mwdata = d;
      end else begin
         exp_mwen = 8'h00;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      logic [63:0] q_rd_seen;
      int          cdc, gcnt, since_sd, max_gap, sg_cnt, dens;

      // Reset with requests pending: grants must stay low
      idle_inputs();
      bus.q_req = 1'b1; bus.s_req = 1'b1;
      hold_reset(4);
      repeat (20) step();

      // qmem write then read back
      bus.q_req = 1'b1; bus.q_wen = 8'h03; bus.q_addr = 16'h0010; bus.q_wdata = 64'h1234;
      step();
      chk("qw_gnt", 64'(obs_qg), 64'd1);
      bus.q_req = 1'b0;
      repeat (2) step();
      bus.q_req = 1'b1; bus.q_wen = 8'h00; bus.q_addr = 16'h0010;
      step();
      chk("qr_gnt", 64'(obs_qg), 64'd1);
      bus.q_req = 1'b0;
      step();
      step();
      q_rd_seen = bus.rd_data;
      chk("qr_done", 64'(obs_qd), 64'd1);
      chk("qr_data16", q_rd_seen[15:0], 64'h1234);

      // 30 back-to-back compute reads while qmem and smem wait
      bus.q_req = 1'b1; bus.q_wen = 8'h00; bus.q_addr = 16'h0020;
      bus.s_req = 1'b1; bus.s_addr = 16'h0030;
      cdc = 0; gcnt = 0;
      for (int i = 0; i < 30; i++) begin
         bus.c_ren = 1'b1; bus.c_addr = 16'(i);
         step();
         cdc += int'(obs_cd); gcnt += int'(obs_qg) + int'(obs_sg);
      end
      bus.c_ren = 1'b0;
      chk("qs_gnt_under_c", 64'(gcnt), 64'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         cdc += int'(obs_cd);
         if (obs_qg) bus.q_req = 1'b0;
         if (obs_sg) bus.s_req = 1'b0;
      end
      chk("c_done_count", 64'(cdc), 64'd30);

      // qmem and smem held continuously, no compute
      bus.q_req = 1'b1; bus.s_req = 1'b1;
      since_sd = -1; max_gap = 0; sg_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (obs_qg) begin
            bus.q_addr = 16'($urandom_range(0, 31)); bus.q_wen = 8'($urandom);
            bus.q_wdata = {$urandom, $urandom};
         end
         if (obs_sd) since_sd = 0;
         if (obs_sg) begin
            sg_cnt++;
            if (since_sd > max_gap) max_gap = since_sd;
            since_sd = -1;
            bus.s_addr = 16'($urandom_range(0, 31));
         end else if (since_sd >= 0) since_sd++;
      end
      chk("s_gnt_seen", 64'(sg_cnt > 0), 64'd1);
      chk("s_regrant_gap", 64'(max_gap <= STARVE_MAX + 1), 64'd1);
      idle_inputs();
      repeat (4) step();

      // compute request in the qmem done cycle defers the qmem re-grant
      bus.q_req = 1'b1; bus.q_wen = 8'hFF; bus.q_addr = 16'h0040; bus.q_wdata = 64'hA5A5_0000_5A5A_FFFF;
      step();
      chk("e_first_gnt", 64'(obs_qg), 64'd1);
      bus.q_wen = 8'h00; bus.q_addr = 16'h0041;
      step();
      bus.c_ren = 1'b1; bus.c_addr = 16'h0042;
      step();
      chk("e_q_done", 64'(obs_qd), 64'd1);
      chk("e_q_deferred", 64'(obs_qg), 64'd0);
      bus.c_ren = 1'b0;
      step();
      chk("e_q_regrant", 64'(obs_qg), 64'd1);
      bus.q_req = 1'b0;
      repeat (4) step();

      // reset while a qmem read is in flight: no done afterwards
      bus.q_req = 1'b1; bus.q_wen = 8'h00; bus.q_addr = 16'h0010;
      step();
      bus.q_req = 1'b0;
      hold_reset(3);
      repeat (4) step();

      // reset while a compute write sits on the port: m_wen drops at once
      bus.c_wen = 8'hFF; bus.c_addr = 16'h0011; bus.c_wdata = 64'h0123_4567_89AB_CDEF;
      step();
      bus.c_wen = 8'h00;
      chk("pre_rst_m_wen", bus.m_wen, 64'hFF);
      rst_n = 1'b0;
      #1;
      chk("async_m_wen_drop", bus.m_wen, 64'd0);
      hold_reset(2);
      repeat (4) step();

      // random three-client traffic with varying compute load
      dens = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) dens = $urandom_range(0, 9);
         if (!bus.q_req && $urandom_range(0, 1) == 1) begin
            bus.q_req = 1'b1;
            bus.q_wen = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            bus.q_addr = 16'($urandom_range(0, 31));
            bus.q_wdata = {$urandom, $urandom};
         end
         if (!bus.s_req && $urandom_range(0, 1) == 1) begin
            bus.s_req = 1'b1;
            bus.s_addr = 16'($urandom_range(0, 31));
         end
         bus.c_ren = 1'b0; bus.c_wen = 8'h00;
         if ($urandom_range(0, 9) < dens) begin
            bus.c_ren = ($urandom_range(0, 1) == 1);
            bus.c_wen = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (!bus.c_ren && bus.c_wen == 8'h00) bus.c_ren = 1'b1;
         end
         bus.c_addr = 16'($urandom_range(0, 31));
         bus.c_wdata = {$urandom, $urandom};
         step();
         if (obs_qg) bus.q_req = 1'b0;
         if (obs_sg) bus.s_req = 1'b0;
      end
      idle_inputs();
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
